// File: rtl/berger_zero_scrubber_if.sv
// berger_zero_scrubber_if: control, status and memory read port bundle for the Berger-zero scrubber
interface berger_zero_scrubber_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CHK_W  = 4,
  parameter int CNT_W  = 5
);
  logic                      start;
  logic                      abort;
  logic                      mem_rd_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W+CHK_W-1:0]   mem_rdata;
  logic                      busy;
  logic                      done;
  logic                      err_pulse;
  logic [ADDR_W-1:0]         err_addr;
  logic [CNT_W-1:0]          err_count;
  logic                      first_err_valid;
  logic [ADDR_W-1:0]         first_err_addr;
  modport master (
    input  start, abort, mem_rdata,
    output mem_rd_en, mem_addr, busy, done, err_pulse, err_addr, err_count, first_err_valid, first_err_addr
  );
  modport slave (
    output start, abort, mem_rdata,
    input  mem_rd_en, mem_addr, busy, done, err_pulse, err_addr, err_count, first_err_valid, first_err_addr
  );
endinterface

// File: rtl/berger_zero_scrubber.sv
// berger_zero_scrubber: walks the Berger-zero memory and counts codewords whose zero count disagrees; BERGER_SCRUB_HALT_EN stops at the first bad word
module berger_zero_scrubber #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CHK_W  = 4,
  parameter int CNT_W  = 5
) (
  input logic clk,
  input logic rst,
  berger_zero_scrubber_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t            state;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CHK_W-1:0]  zeros;
  logic              bad;
  logic              halt;
  logic              stop;
  logic              chk_en;
  // zero count of the returned data word against its stored check field
  always_comb begin
    zeros = '0;
    for (int i = 0; i < DATA_W; i++) zeros = zeros + CHK_W'(!bus.mem_rdata[CHK_W+i]);
    bad = zeros != bus.mem_rdata[CHK_W-1:0];
`ifdef BERGER_SCRUB_HALT_EN
    halt = bus.first_err_valid;
    stop = bus.err_pulse;
`else
    halt = 1'b0;
    stop = 1'b0;
`endif
    chk_en = rd_q && (state == ISSUE || state == DRAIN) && !bus.abort && !halt;
  end
  // scan sequencer, read qualification pipeline and error bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      rd_q                <= 1'b0;
      addr_q              <= '0;
      bus.mem_rd_en       <= 1'b0;
      bus.mem_addr        <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.err_pulse       <= 1'b0;
      bus.err_addr        <= '0;
      bus.err_count       <= '0;
      bus.first_err_valid <= 1'b0;
      bus.first_err_addr  <= '0;
    end else begin
      rd_q          <= bus.mem_rd_en;
      addr_q        <= bus.mem_addr;
      bus.err_pulse <= 1'b0;
      bus.done      <= 1'b0;
      if (chk_en && bad) begin
        bus.err_pulse <= 1'b1;
        bus.err_addr  <= addr_q;
        bus.err_count <= &bus.err_count ? bus.err_count : bus.err_count + 1'b1;
        if (!bus.first_err_valid) begin
          bus.first_err_valid <= 1'b1;
          bus.first_err_addr  <= addr_q;
        end
      end
      case (state)
        IDLE: if (bus.start && !bus.abort) begin
          state               <= ISSUE;
          bus.busy            <= 1'b1;
          bus.mem_rd_en       <= 1'b1;
          bus.mem_addr        <= '0;
          bus.err_count       <= '0;
          bus.first_err_valid <= 1'b0;
          bus.first_err_addr  <= '0;
        end
        ISSUE: if (bus.abort) begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.mem_rd_en <= 1'b0;
        end else if (bus.mem_addr == LAST || stop) begin
          state         <= DRAIN;
          bus.mem_rd_en <= 1'b0;
        end else begin
          bus.mem_addr <= bus.mem_addr + 1'b1;
        end
        DRAIN: begin
          state    <= bus.abort ? IDLE : DONE;
          bus.busy <= 1'b0;
          bus.done <= !bus.abort;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_berger_zero_scrubber.sv
// tb_berger_zero_scrubber: scoreboard bench for the Berger-zero scrubber with a synchronous memory model
module tb_berger_zero_scrubber;
  localparam int N = 16;
  typedef struct {int cnt; int fev; int fea; int cyc;} done_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  logic [11:0] mem [N];
  int bad[$];
  int xe[$];
  int rq[$];
  int eq[$];
  done_t dq[$];
  berger_zero_scrubber_if bus ();
  berger_zero_scrubber dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic fail(string n, logic [31:0] act);
    nchk++;
    nerr++;
    $display("FAIL %s: got %0d with nothing expected", n, act);
  endtask
  function automatic logic [11:0] enc(logic [7:0] d);
    int z = 0;
    for (int i = 0; i < 8; i++) z += int'(!d[i]);
    return {d, 4'(z)};
  endfunction
  // monitor: every read, error pulse and done is popped against the scoreboard
  always @(negedge clk) if (!rst) begin
    if (bus.mem_rd_en) begin
      if (rq.size() == 0) fail("unexpected_read", 32'(bus.mem_addr));
      else chk("rd_addr", 32'(bus.mem_addr), rq.pop_front());
    end
    if (bus.err_pulse) begin
      if (eq.size() == 0) fail("unexpected_err_pulse", 32'(bus.err_addr));
      else chk("err_addr", 32'(bus.err_addr), eq.pop_front());
    end
    if (bus.done) begin
      if (dq.size() == 0) fail("unexpected_done", cyc);
      else begin
        done_t e;
        e = dq.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("err_count", 32'(bus.err_count), e.cnt);
        chk("first_err_valid", 32'(bus.first_err_valid), e.fev);
        chk("first_err_addr", 32'(bus.first_err_addr), e.fea);
        chk("pulses_missing_at_done", eq.size(), 0);
        chk("busy_at_done", 32'(bus.busy), 0);
      end
    end
  end
  task automatic scan(input int nreads, input int doff, input bit exp_done, output int s);
    done_t d;
    for (int i = 0; i < N; i++) mem[i] = enc(8'(i));
    foreach (bad[k]) mem[bad[k]] = enc(8'(bad[k])) | 12'h100;
    @(negedge clk);
    s = cyc + 1;
    for (int r = 0; r < nreads; r++) rq.push_back(r);
    foreach (xe[k]) eq.push_back(xe[k]);
    d.cnt = xe.size();
    d.fev = xe.size() > 0 ? 1 : 0;
    d.fea = xe.size() > 0 ? xe[0] : 0;
    d.cyc = s + doff;
    if (exp_done) dq.push_back(d);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic settle(string tag);
    repeat (24) @(negedge clk);
    chk({tag, "_reads_left"}, rq.size(), 0);
    chk({tag, "_pulses_left"}, eq.size(), 0);
    chk({tag, "_done_left"}, dq.size(), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask
  task automatic all_zero(string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_err_pulse"}, 32'(bus.err_pulse), 0);
    chk({tag, "_err_addr"}, 32'(bus.err_addr), 0);
    chk({tag, "_err_count"}, 32'(bus.err_count), 0);
    chk({tag, "_fev"}, 32'(bus.first_err_valid), 0);
    chk({tag, "_fea"}, 32'(bus.first_err_addr), 0);
  endtask
  initial begin
    int s;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst = 1'b0;
    bad = {}; xe = {};
    scan(16, 17, 1, s);
    settle("clean");
    bad = '{5}; xe = '{5};
    scan(16, 17, 1, s);
    settle("single");
    bad = '{2, 9, 15}; xe = '{2, 9, 15};
    scan(16, 17, 1, s);
    settle("triple");
    chk("triple_hold_count", 32'(bus.err_count), 3);
    chk("triple_hold_first", 32'(bus.first_err_addr), 2);
    bad = {}; xe = {};
    scan(16, 17, 1, s);
    for (int k = 1; k <= 17; k++) begin
      bus.start = (k == 3 || k == 10 || k == 17);
      @(negedge clk);
    end
    bus.start = 1'b0;
    settle("restart_ignored");
    bad = '{2, 6}; xe = '{2};
    scan(8, 0, 0, s);
    repeat (7) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_rd_en", 32'(bus.mem_rd_en), 0);
    settle("abort");
    chk("abort_partial_count", 32'(bus.err_count), 1);
    chk("abort_partial_first", 32'(bus.first_err_addr), 2);
    bad = {}; xe = {};
    scan(16, 17, 1, s);
    settle("after_abort");
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 32'(bus.busy), 0);
    chk("start_abort_rd_en", 32'(bus.mem_rd_en), 0);
    settle("start_abort");
    bad = '{4, 7};
`ifdef BERGER_SCRUB_HALT_EN
    xe = '{4};
    scan(7, 8, 1, s);
`else
    xe = '{4, 7};
    scan(16, 17, 1, s);
`endif
    settle("two_bad");
    bad = '{3}; xe = '{3};
    scan(16, 17, 1, s);
    repeat (6) @(negedge clk);
    chk("pre_reset_count", 32'(bus.err_count), 1);
    #2 rst = 1'b1;
    #1 all_zero("async_reset");
    rq.delete();
    eq.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle("post_reset");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
